// File: rtl/cr_huf_comp_long_hist.sv
// Long-symbol histogram: counts FIFO pops per block, streams counts on EOB.
// Optional CR_HUF_COMP_LONG_HIST_SKIP_ZERO_EN drops zero-count beats from the dump.
package cr_huf_comp_long_hist_pkg;
  typedef struct packed {
    logic [2:0] cnt;
    logic [7:0] long;
    logic [3:0] seq_id;
    logic [1:0] eob;
  } s_sc_is_long_intf;
endpackage

import cr_huf_comp_long_hist_pkg::*;

module cr_huf_comp_long_hist #(
  parameter int SYM_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sc_is_long_vld,
  input  s_sc_is_long_intf sc_is_long_intf,
  output logic             is_sc_long_rd,
  output logic             hist_vld,
  input  logic             hist_rdy,
  output logic [SYM_W-1:0] hist_sym,
  output logic [CNT_W-1:0] hist_cnt,
  output logic [3:0]       hist_seq_id,
  output logic             hist_last,
  output logic             seq_err
);

  localparam int NSYM = 1 << SYM_W;
  localparam logic [SYM_W-1:0] LAST = '1;

  typedef enum logic {ACC, DUMP} state_e;

  state_e           state_q;
  logic [SYM_W-1:0] idx_q;
  logic [3:0]       seq_q;
  logic             first_q;
  logic             seq_err_q;
  logic [CNT_W-1:0] cnt_q [NSYM];

  logic             acc;
  logic             pop;
  logic [SYM_W-1:0] sym;
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] sat_d;
  logic [CNT_W-1:0] cur_cnt;
  logic             skip;
  logic             beat_vld;
  logic             fire;
  logic             adv;
  logic             is_last;

  always_comb begin
    acc     = (state_q == ACC);
    pop     = acc & sc_is_long_vld;
    sym     = sc_is_long_intf.long[SYM_W-1:0];
    sum     = {1'b0, cnt_q[sym]} + (CNT_W+1)'(sc_is_long_intf.cnt);
    sat_d   = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    cur_cnt = cnt_q[idx_q];
    is_last = (idx_q == LAST);
`ifdef CR_HUF_COMP_LONG_HIST_SKIP_ZERO_EN
    skip    = !acc && (cur_cnt == '0) && !is_last;
`else
    skip    = 1'b0;
`endif
    beat_vld = !acc && !skip;
    fire     = beat_vld & hist_rdy;
    adv      = fire | skip;
  end

  assign is_sc_long_rd = pop;
  assign hist_vld      = beat_vld;
  assign hist_sym      = acc ? '0 : idx_q;
  assign hist_cnt      = acc ? '0 : cur_cnt;
  assign hist_seq_id   = acc ? '0 : seq_q;
  assign hist_last     = beat_vld & is_last;
  assign seq_err       = seq_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACC;
      idx_q     <= '0;
      seq_q     <= '0;
      first_q   <= 1'b1;
      seq_err_q <= 1'b0;
    end else begin
      seq_err_q <= pop && !first_q &&
                   (sc_is_long_intf.seq_id != seq_q);
      unique case (state_q)
        ACC: begin
          if (pop) begin
            if (first_q) begin
              seq_q   <= sc_is_long_intf.seq_id;
              first_q <= 1'b0;
            end
            if (sc_is_long_intf.eob != 2'd0) begin
              state_q <= DUMP;
              idx_q   <= '0;
            end
          end
        end
        DUMP: begin
          if (adv) idx_q <= idx_q + 1'b1;
          if (fire && is_last) begin
            state_q <= ACC;
            first_q <= 1'b1;
          end
        end
        default: state_q <= ACC;
      endcase
    end
  end

  // Pops and dump clears never coincide: they live in different states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSYM; i++) cnt_q[i] <= '0;
    end else if (pop) begin
      cnt_q[sym] <= sat_d;
    end else if (fire) begin
      cnt_q[idx_q] <= '0;
    end
  end

endmodule

// File: tb/tb_cr_huf_comp_long_hist.sv
// Randomized bench for cr_huf_comp_long_hist against a per-block count model.
// Honours CR_HUF_COMP_LONG_HIST_SKIP_ZERO_EN the same way as the design.
import cr_huf_comp_long_hist_pkg::*;

module tb_cr_huf_comp_long_hist;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             sc_is_long_vld;
  s_sc_is_long_intf ent;
  logic             is_sc_long_rd;
  logic             hist_vld;
  logic             hist_rdy;
  logic [7:0]       hist_sym;
  logic [15:0]      hist_cnt;
  logic [3:0]       hist_seq_id;
  logic             hist_last;
  logic             seq_err;

  int passed = 0;
  int total  = 0;

  int model [256];
  int mseq;
  bit mfirst;
  bit last_err;

`ifdef CR_HUF_COMP_LONG_HIST_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  always #5 clk = ~clk;

  cr_huf_comp_long_hist dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sc_is_long_vld  (sc_is_long_vld),
    .sc_is_long_intf (ent),
    .is_sc_long_rd   (is_sc_long_rd),
    .hist_vld        (hist_vld),
    .hist_rdy        (hist_rdy),
    .hist_sym        (hist_sym),
    .hist_cnt        (hist_cnt),
    .hist_seq_id     (hist_seq_id),
    .hist_last       (hist_last),
    .seq_err         (seq_err)
  );

  function automatic void model_clear();
    for (int i = 0; i < 256; i++) model[i] = 0;
    mseq     = 0;
    mfirst   = 1'b1;
    last_err = 1'b0;
  endfunction

  function automatic int next_sym(input int s);
    int k;
    k = s;
    if (SKIP)
      while (k < 255 && model[k] == 0) k++;
    return k;
  endfunction

  task automatic push(input int l, input int c, input int s, input int e);
    @(negedge clk);
    sc_is_long_vld = 1'b1;
    ent.long   = 8'(l);
    ent.cnt    = 3'(c);
    ent.seq_id = 4'(s);
    ent.eob    = 2'(e);
    #1;
    total++;
    if (is_sc_long_rd !== 1'b1)
      $display("FAIL pop_rd: rd=%b required 1 (long=%0d)", is_sc_long_rd, l);
    else passed++;
    @(posedge clk);
    model[l] = (model[l] + c > 65535) ? 65535 : model[l] + c;
    last_err = !mfirst && (s != mseq);
    if (mfirst) begin
      mseq   = s;
      mfirst = 1'b0;
    end
  endtask

  task automatic drain(input bit rnd, input int stop_at,
                       output int beats, output int cyc);
    int   exp;
    bit   done;
    bit   held;
    logic [7:0]  p_sym;
    logic [15:0] p_cnt;
    logic        p_last;
    beats = 0;
    cyc   = 0;
    done  = 1'b0;
    held  = 1'b0;
    p_sym = '0; p_cnt = '0; p_last = 1'b0;
    exp   = next_sym(0);
    for (int n = 0; n < 3000 && !done && beats != stop_at; n++) begin
      @(negedge clk);
      sc_is_long_vld = 1'b1;
      ent      = '0;
      hist_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      cyc++;
      total++;
      if (is_sc_long_rd !== 1'b0)
        $display("FAIL dump_rd: rd=%b required 0 at cycle %0d", is_sc_long_rd, cyc);
      else passed++;
      total++;
      if (seq_err !== (cyc == 1 ? last_err : 1'b0))
        $display("FAIL seq_err: got %b required %b at dump cycle %0d",
                 seq_err, (cyc == 1 ? last_err : 1'b0), cyc);
      else passed++;
      if (!SKIP) begin
        total++;
        if (hist_vld !== 1'b1)
          $display("FAIL dump_vld: got %b required 1 at cycle %0d", hist_vld, cyc);
        else passed++;
      end
      if (held) begin
        total++;
        if (hist_vld !== 1'b1 || hist_sym !== p_sym ||
            hist_cnt !== p_cnt || hist_last !== p_last)
          $display("FAIL hold: vld=%b sym=%0d cnt=%0d last=%b required 1/%0d/%0d/%b",
                   hist_vld, hist_sym, hist_cnt, hist_last, p_sym, p_cnt, p_last);
        else passed++;
      end
      held = 1'b0;
      if (hist_vld === 1'b1) begin
        total++;
        if (hist_sym !== 8'(exp))
          $display("FAIL beat_sym: got %0d required %0d", hist_sym, exp);
        else passed++;
        total++;
        if (hist_cnt !== 16'(model[exp]))
          $display("FAIL beat_cnt: sym %0d got %0d required %0d",
                   exp, hist_cnt, model[exp]);
        else passed++;
        total++;
        if (hist_seq_id !== 4'(mseq))
          $display("FAIL beat_seq: got %0d required %0d", hist_seq_id, mseq);
        else passed++;
        total++;
        if (hist_last !== (exp == 255))
          $display("FAIL beat_last: sym %0d got %b required %b",
                   exp, hist_last, (exp == 255));
        else passed++;
        if (hist_rdy) begin
          beats++;
          model[exp] = 0;
          if (exp == 255) done = 1'b1;
          else exp = next_sym(exp + 1);
        end else begin
          held   = 1'b1;
          p_sym  = hist_sym;
          p_cnt  = hist_cnt;
          p_last = hist_last;
        end
      end
      @(posedge clk);
    end
    total++;
    if (!done && beats != stop_at)
      $display("FAIL dump_timeout: %0d beats after %0d cycles", beats, cyc);
    else passed++;
    if (done) begin
      mfirst = 1'b1;
      @(negedge clk);
      #1;
      total++;
      if (is_sc_long_rd !== 1'b1)
        $display("FAIL exit_rd: rd=%b required 1 after last beat", is_sc_long_rd);
      else passed++;
      sc_is_long_vld = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sc_is_long_vld = 1'b0;
    ent = '0;
    hist_rdy = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    total++;
    if ({is_sc_long_rd, hist_vld, hist_sym, hist_cnt,
         hist_seq_id, hist_last, seq_err} !== '0)
      $display("FAIL reset_outs: rd=%b vld=%b sym=%0d cnt=%0d seq=%0d last=%b err=%b required all 0",
               is_sc_long_rd, hist_vld, hist_sym, hist_cnt,
               hist_seq_id, hist_last, seq_err);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int b, c;
    repeat (3) push(5, 1, 3, 0);
    push(9, 1, 3, 1);
    drain(1'b0, -1, b, c);
    total++;
    if (c != 256)
      $display("FAIL basic_rd_low: %0d cycles required 256", c);
    else passed++;
    total++;
    if (b != (SKIP ? 3 : 256))
      $display("FAIL basic_beats: %0d required %0d", b, (SKIP ? 3 : 256));
    else passed++;
  endtask

  task automatic test_saturate();
    int b, c;
    for (int i = 0; i < 65539; i++) push(7, 1, 1, 0);
    push(7, 1, 1, 2);
    total++;
    if (model[7] != 65535)
      $display("FAIL sat_model: %0d required 65535", model[7]);
    else passed++;
    drain(1'b0, -1, b, c);
  endtask

  task automatic test_seq();
    int b, c;
    push(20, 1, 2, 0);
    push(20, 1, 2, 0);
    push(21, 1, 4, 3);
    total++;
    if (!last_err || mseq != 2)
      $display("FAIL seq_model: err=%b seq=%0d required 1/2", last_err, mseq);
    else passed++;
    drain(1'b0, -1, b, c);
  endtask

  task automatic test_random_rdy();
    int b, c, s;
    s = $urandom_range(0, 15);
    for (int i = 0; i < 40; i++)
      push($urandom_range(0, 255), $urandom_range(0, 1), s, 0);
    push($urandom_range(0, 255), 1, s, $urandom_range(1, 3));
    drain(1'b1, -1, b, c);
  endtask

  task automatic test_marker();
    int b, c;
    push($urandom_range(0, 255), 0, 5, 1);
    drain(1'b0, -1, b, c);
    total++;
    if (b != (SKIP ? 1 : 256))
      $display("FAIL marker_beats: %0d required %0d", b, (SKIP ? 1 : 256));
    else passed++;
  endtask

  task automatic test_midreset();
    int b, c;
    for (int i = 0; i < 200; i++) push(i, 1, 9, (i == 199) ? 1 : 0);
    drain(1'b0, 100, b, c);
    @(negedge clk);
    rst_n = 1'b0;
    sc_is_long_vld = 1'b0;
    #1;
    total++;
    if (hist_vld !== 1'b0 || hist_last !== 1'b0 || is_sc_long_rd !== 1'b0)
      $display("FAIL midreset: vld=%b last=%b rd=%b required 0/0/0",
               hist_vld, hist_last, is_sc_long_rd);
    else passed++;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    push(3, 1, 11, 0);
    push(3, 1, 11, 0);
    push(250, 1, 11, 1);
    drain(1'b0, -1, b, c);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_seq();
    test_random_rdy();
    test_marker();
    test_random_rdy();
    test_midreset();
    test_saturate();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
